// File: rtl/pipelined_brent_kung_addsub.sv
// N-bit add/subtract: CLA inside each group, Brent-Kung prefix over group carries,
// prefix levels spread across STAGES registers with valid/ready backpressure.
module pipelined_brent_kung_addsub #(
   parameter int N          = 16,
   parameter int GROUP_SIZE = 4,
   parameter int STAGES     = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   input  logic         Sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] Sum,
   output logic         Cout,
   output logic         Ovf
);

   localparam int NG     = N / GROUP_SIZE;
   localparam int D      = (NG > 1) ? $clog2(NG) : 0;
   // level 0: in-group lookahead, 1..D: up-sweep, D+1..2D-1: down-sweep, last: group fix-up
   localparam int LEVELS = 2 + D + ((D > 0) ? D - 1 : 0);

   typedef struct packed {
      logic [N-1:0] g;
      logic [N-1:0] p;
      logic [N-1:0] h;
      logic         c0;
      logic         a_msb;
      logic         b_msb;
   } gp_t;

   // first prefix level applied in stage k; stage 0 only registers raw g/p when STAGES > 1
   function automatic int level_first(int k);
      if (k == 0) return 0;
      if (STAGES == 1) return LEVELS;
      return ((k - 1) * LEVELS) / (STAGES - 1);
   endfunction

   function automatic gp_t apply_level(gp_t x, int lvl);
      gp_t y;
      int  top;
      int  lo;
      int  d;
      y = x;
      if (lvl == 0) begin
         for (int j = 0; j < NG; j++) begin
            for (int i = 1; i < GROUP_SIZE; i++) begin
               top = j * GROUP_SIZE + i;
               y.g[top] = x.g[top] | (x.p[top] & y.g[top-1]);
               y.p[top] = x.p[top] & y.p[top-1];
            end
         end
      end else if (lvl == LEVELS - 1) begin
         for (int j = 1; j < NG; j++) begin
            lo = j * GROUP_SIZE - 1;
            for (int i = 0; i < GROUP_SIZE - 1; i++) begin
               top = j * GROUP_SIZE + i;
               y.g[top] = x.g[top] | (x.p[top] & x.g[lo]);
               y.p[top] = x.p[top] & x.p[lo];
            end
         end
      end else begin
         d = (lvl <= D) ? lvl - 1 : 2 * D - 1 - lvl;
         for (int j = 0; j < NG; j++) begin
            if ((lvl <= D) ? ((j + 1) % (2 ** (d + 1)) == 0)
                           : (((j + 1) % (2 ** (d + 1)) == 2 ** d) && (j + 1 > 2 ** d))) begin
               top = j * GROUP_SIZE + GROUP_SIZE - 1;
               lo  = top - (2 ** d) * GROUP_SIZE;
               y.g[top] = x.g[top] | (x.p[top] & x.g[lo]);
               y.p[top] = x.p[top] & x.p[lo];
            end
         end
      end
      return y;
   endfunction

   function automatic gp_t apply_range(gp_t x, int lo, int hi);
      gp_t y;
      y = x;
      for (int l = 0; l < LEVELS; l++) begin
         if (l >= lo && l < hi) y = apply_level(y, l);
      end
      return y;
   endfunction

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] take;
   logic              stall;
   logic              advance;
   logic [N-1:0]      b_eff;
   logic              c_eff;
   gp_t               in_gp;
   gp_t               stage_in  [STAGES];
   gp_t               stage_out [STAGES];
   logic [N-1:0]      res_sum;
   logic              res_ovf;

   assign out_valid = vld[STAGES-1];
   assign stall     = out_valid & ~out_ready;
   assign advance   = ~stall;
   assign in_ready  = advance;

   // carry-in is folded into bit 0 so the prefix G at bit i is the carry out of bit i
   always_comb begin
      b_eff       = Sub ? ~B : B;
      c_eff       = Sub ? ~Cin : Cin;
      in_gp.h     = A ^ b_eff;
      in_gp.p     = A ^ b_eff;
      in_gp.p[0]  = 1'b0;
      in_gp.g     = A & b_eff;
      in_gp.g[0]  = (A[0] & b_eff[0]) | ((A[0] ^ b_eff[0]) & c_eff);
      in_gp.c0    = c_eff;
      in_gp.a_msb = A[N-1];
      in_gp.b_msb = b_eff[N-1];
   end

   assign stage_in[0] = in_gp;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      assign stage_out[k] = apply_range(stage_in[k], level_first(k), level_first(k + 1));
      if (k == 0) begin : g_take_in
         assign take[k] = in_valid;
      end else begin : g_take_vld
         assign take[k] = vld[k-1];
      end
      if (k < STAGES - 1) begin : g_reg
         gp_t q;
         // stage k -> k+1 boundary
         always_ff @(posedge clk) begin
            if (advance && take[k]) q <= stage_out[k];
         end
         assign stage_in[k+1] = q;
      end
   end

   assign res_sum = stage_out[STAGES-1].h ^ {stage_out[STAGES-1].g[N-2:0], stage_out[STAGES-1].c0};
   assign res_ovf = (stage_out[STAGES-1].a_msb == stage_out[STAGES-1].b_msb) &&
                    (res_sum[N-1] != stage_out[STAGES-1].a_msb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
      end else if (advance) begin
         for (int k = STAGES - 1; k > 0; k--) vld[k] <= vld[k-1];
         vld[0] <= in_valid;
      end
   end

   // output stage boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Sum  <= '0;
         Cout <= 1'b0;
         Ovf  <= 1'b0;
      end else if (advance && take[STAGES-1]) begin
         Sum  <= res_sum;
         Cout <= stage_out[STAGES-1].g[N-1];
         Ovf  <= res_ovf;
      end
   end

endmodule

// File: tb/tb_pipelined_brent_kung_addsub.sv
// Bench for pipelined_brent_kung_addsub: directed literal cases on a 16-bit/3-stage
// instance plus randomized traffic on several widths/depths against an arithmetic model.
module tb_pipelined_brent_kung_addsub;

   localparam int N      = 16;
   localparam int STAGES = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, Cin, Sub, out_valid, out_ready, Cout, Ovf;
   logic [N-1:0] A, B, Sum;

   int checks   = 0;
   int failures = 0;
   bit go_rand  = 1'b0;
   int rand_done = 0;

   typedef struct packed {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   always #5 clk = ~clk;

   pipelined_brent_kung_addsub #(.N(N), .GROUP_SIZE(4), .STAGES(STAGES)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
      .Sum(Sum), .Cout(Cout), .Ovf(Ovf));

   // exact arithmetic: unsigned result/carry and signed range test for overflow
   function automatic res_t model(int n, longint unsigned a, longint unsigned b, bit cin, bit sub);
      res_t            r;
      longint unsigned m, full;
      longint          sa, sb, sr, lim;
      m   = (64'd1 << n) - 64'd1;
      lim = longint'(64'd1 << (n - 1));
      sa  = (a >= 64'(lim)) ? longint'(a) - 2 * lim : longint'(a);
      sb  = (b >= 64'(lim)) ? longint'(b) - 2 * lim : longint'(b);
      if (sub) begin
         full   = (a - b - 64'(cin)) & m;
         r.cout = (a >= b + 64'(cin));
         sr     = sa - sb - longint'(64'(cin));
      end else begin
         full   = a + b + 64'(cin);
         r.cout = ((full >> n) & 64'd1) != 64'd0;
         full   = full & m;
         sr     = sa + sb + longint'(64'(cin));
      end
      r.sum = full;
      r.ovf = (sr >= lim) || (sr < -lim);
      return r;
   endfunction

   function automatic int cfg_n(int i);
      case (i)
         0: return 8;
         1: return 16;
         2: return 32;
         default: return 32;
      endcase
   endfunction

   function automatic int cfg_s(int i);
      case (i)
         0: return 1;
         1: return 2;
         2: return 4;
         default: return 1;
      endcase
   endfunction

   function automatic int cfg_g(int i);
      case (i)
         0: return 4;
         1: return 2;
         2: return 4;
         default: return 8;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard for the main instance
   res_t         q[$];
   res_t         e_main;
   logic [N+1:0] held;
   bit           was_stall = 1'b0;
   int           rx = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         was_stall = 1'b0;
      end else begin
         check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
         if (was_stall) check("stall_hold", 64'({out_valid, Sum, Cout, Ovf}), 64'({1'b1, held}));
         was_stall = out_valid && !out_ready;
         held      = {Sum, Cout, Ovf};
         if (in_valid && in_ready) q.push_back(model(N, 64'(A), 64'(B), Cin, Sub));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%0h required=none", Sum);
            end else begin
               e_main = q.pop_front();
               check("result", 64'({Sum, Cout, Ovf}), 64'({e_main.sum[N-1:0], e_main.cout, e_main.ovf}));
               rx++;
            end
         end
      end
   end

   task automatic expect_single(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic cin, input logic sub, input logic [N-1:0] esum,
                                input logic ecout, input logic eovf);
      tick();
      A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check({name, "_accept"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= STAGES; i++) begin
         @(negedge clk);
         if (i < STAGES) check({name, "_early"}, 64'(out_valid), 64'd0);
         else check(name, 64'({out_valid, Sum, Cout, Ovf}), 64'({1'b1, esum, ecout, eovf}));
      end
   endtask

   initial begin
      int   cyc, stall_cycles, rx0, sent, guard;
      bit   acc, pend;
      res_t r;

      rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b1;

      r = model(16, 64'hFFFF, 64'h0000, 1'b1, 1'b0);
      check("model_pin_carry", 64'({r.sum[15:0], r.cout, r.ovf}), 64'({16'h0000, 1'b1, 1'b0}));
      r = model(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0);
      check("model_pin_ovf", 64'({r.sum[15:0], r.cout, r.ovf}), 64'({16'h8000, 1'b0, 1'b1}));
      r = model(16, 64'h0007, 64'h0007, 1'b1, 1'b1);
      check("model_pin_borrow", 64'({r.sum[15:0], r.cout, r.ovf}), 64'({16'hFFFF, 1'b0, 1'b0}));
      r = model(8, 64'h80, 64'h01, 1'b0, 1'b1);
      check("model_pin_sub8", 64'({r.sum[7:0], r.cout, r.ovf}), 64'({8'h7F, 1'b1, 1'b1}));

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("in_reset", 64'({out_valid, Sum, Cout, Ovf}), 64'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("reset_idle", 64'({out_valid, in_ready, Sum, Cout, Ovf}),
               64'({1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}));
      end

      expect_single("add_carry",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      expect_single("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      expect_single("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      expect_single("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      expect_single("sub_borrow", 16'h0007, 16'h0007, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

      // backpressure: 8 back-to-back beats, consumer stalls on cycles 4..9
      tick();
      cyc = 0; stall_cycles = 0; rx0 = rx;
      for (int j = 0; j < 8; j++) begin
         A = N'($urandom); B = N'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
         in_valid = 1'b1;
         acc = 1'b0; guard = 0;
         while (!acc && guard < 40) begin
            out_ready = !(cyc >= 4 && cyc <= 9);
            @(negedge clk);
            acc = in_ready;
            if (out_valid && !out_ready) stall_cycles++;
            tick();
            cyc++; guard++;
         end
         if (!acc) begin
            checks++; failures++;
            $display("FAIL bp_accept_timeout actual=%0d required=accepted", j);
         end
      end
      in_valid = 1'b0;
      guard = 0;
      while ((q.size() > 0 || out_valid) && guard < 50) begin
         out_ready = !(cyc >= 4 && cyc <= 9);
         @(negedge clk);
         if (out_valid && !out_ready) stall_cycles++;
         tick();
         cyc++; guard++;
      end
      out_ready = 1'b1;
      check("bp_stall_cycles", 64'(stall_cycles), 64'd6);
      check("bp_delivered", 64'(rx - rx0), 64'd8);

      // reset with three beats in flight
      for (int j = 0; j < 3; j++) begin
         A = N'($urandom); B = N'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_reset_drop", 64'({out_valid, Sum, Cout, Ovf}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_stale", 64'(out_valid), 64'd0);
      end
      expect_single("after_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

      // randomized traffic on the main instance
      tick();
      sent = 0; guard = 0; pend = 1'b0;
      while (sent < 3000 && guard < 30000) begin
         if (!pend && $urandom_range(0, 3) != 0) begin
            A = N'($urandom); B = N'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
            in_valid = 1'b1; pend = 1'b1;
         end
         out_ready = 1'($urandom);
         @(negedge clk);
         if (in_valid && in_ready) begin
            sent++; pend = 1'b0;
         end
         tick();
         if (!pend) in_valid = 1'b0;
         guard++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("rand_sent", 64'(sent), 64'd3000);
      guard = 0;
      while (q.size() > 0 && guard < 100) begin
         tick();
         guard++;
      end
      check("rand_drained", 64'(q.size()), 64'd0);

      go_rand = 1'b1;
      guard = 0;
      while (rand_done < 4 && guard < 60000) begin
         @(posedge clk);
         guard++;
      end
      check("cfg_runs_done", 64'(rand_done), 64'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // other widths, depths and group sizes under random traffic
   for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
      localparam int CN = cfg_n(gi);
      localparam int CS = cfg_s(gi);
      localparam int CG = cfg_g(gi);

      logic          iv, ir, ci, sb, ov, ordy, co, of;
      logic [CN-1:0] a, b, s;
      res_t          cq[$];
      res_t          ce;

      pipelined_brent_kung_addsub #(.N(CN), .GROUP_SIZE(CG), .STAGES(CS)) dut_cfg (
         .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
         .A(a), .B(b), .Cin(ci), .Sub(sb), .out_valid(ov), .out_ready(ordy),
         .Sum(s), .Cout(co), .Ovf(of));

      initial begin
         int sent, guard;
         bit pend;
         iv = 1'b0; a = '0; b = '0; ci = 1'b0; sb = 1'b0; ordy = 1'b1;
         wait (go_rand);
         tick();
         sent = 0; guard = 0; pend = 1'b0;
         while (sent < 2000 && guard < 20000) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
               a = CN'({$urandom, $urandom}); b = CN'({$urandom, $urandom});
               ci = 1'($urandom); sb = 1'($urandom);
               iv = 1'b1; pend = 1'b1;
            end
            ordy = 1'($urandom);
            @(negedge clk);
            if (iv && ir) begin
               sent++; pend = 1'b0;
            end
            tick();
            if (!pend) iv = 1'b0;
            guard++;
         end
         iv = 1'b0; ordy = 1'b1;
         check($sformatf("cfg%0d_sent", gi), 64'(sent), 64'd2000);
         guard = 0;
         while (cq.size() > 0 && guard < 100) begin
            tick();
            guard++;
         end
         check($sformatf("cfg%0d_drained", gi), 64'(cq.size()), 64'd0);
         rand_done++;
      end

      always @(negedge clk) begin
         if (rst_n) begin
            if (iv && ir) cq.push_back(model(CN, 64'(a), 64'(b), ci, sb));
            if (ov && ordy) begin
               if (cq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL cfg%0d_unexpected actual=%0h required=none", gi, s);
               end else begin
                  ce = cq.pop_front();
                  check($sformatf("cfg%0d_result", gi), 64'({s, co, of}),
                        64'({ce.sum[CN-1:0], ce.cout, ce.ovf}));
               end
            end
         end
      end
   end

endmodule
